// File: rtl/gcd_unit.sv
// Multi-cycle binary (Stein) GCD engine with START/BUSY/READY handshake.
// One reduction step per clock in RUN; CYCLES counts RUN edges (saturating).
module gcd_unit #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [W-1:0]  X,
  input  logic [W-1:0]  Y,
  output logic [W-1:0]  OUT,
  output logic          READY,
  output logic          BUSY,
  output logic [CW-1:0] CYCLES
);
  localparam int KW = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_a, r_b, r_out;
  logic [W-1:0]  w_a_nxt, w_b_nxt, w_out_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [CW-1:0] r_cyc, w_cyc_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_k_nxt     = r_k;
    w_cyc_nxt   = r_cyc;
    w_out_nxt   = r_out;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (START) begin
          w_a_nxt     = X;
          w_b_nxt     = Y;
          w_k_nxt     = '0;
          w_cyc_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cyc != {CW{1'b1}}) w_cyc_nxt = r_cyc + 1'b1;
        // Priority order matters: zero tests first, then common factor of two.
        if (r_a == '0) begin
          w_out_nxt   = r_b << r_k;
          w_state_nxt = S_DONE;
        end else if (r_b == '0) begin
          w_out_nxt   = r_a << r_k;
          w_state_nxt = S_DONE;
        end else if (!r_a[0] && !r_b[0]) begin
          w_a_nxt = r_a >> 1;
          w_b_nxt = r_b >> 1;
          w_k_nxt = r_k + 1'b1;
        end else if (!r_a[0]) begin
          w_a_nxt = r_a >> 1;
        end else if (!r_b[0]) begin
          w_b_nxt = r_b >> 1;
        end else if (r_a >= r_b) begin
          w_a_nxt = r_a - r_b;
        end else begin
          w_b_nxt = r_b - r_a;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_a   <= '0;
      r_b   <= '0;
      r_k   <= '0;
      r_cyc <= '0;
      r_out <= '0;
    end else begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_k   <= w_k_nxt;
      r_cyc <= w_cyc_nxt;
      r_out <= w_out_nxt;
    end
  end

  assign OUT    = r_out;
  assign CYCLES = r_cyc;
  assign READY  = (r_state == S_DONE);
  assign BUSY   = (r_state == S_RUN);
endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: vector table, corner sequences, random regression.
// Expected results come from a Euclid GCD and a step-count model, queued per op.
module tb_gcd_unit;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [15:0] X = '0, Y = '0;
  logic [15:0] OUT;
  logic        READY, BUSY;
  logic [7:0]  CYCLES;

  logic        START8 = 1'b0;
  logic [7:0]  X8 = '0, Y8 = '0;
  logic [7:0]  OUT8;
  logic        READY8, BUSY8;
  logic [7:0]  CYCLES8;

  int checks = 0;
  int errors = 0;

  gcd_unit #(.W(16), .CW(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .X(X), .Y(Y),
    .OUT(OUT), .READY(READY), .BUSY(BUSY), .CYCLES(CYCLES)
  );

  gcd_unit #(.W(8), .CW(8)) dut8 (
    .CLK(CLK), .RESET(RESET), .START(START8), .X(X8), .Y(Y8),
    .OUT(OUT8), .READY(READY8), .BUSY(BUSY8), .CYCLES(CYCLES8)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] out;
    logic [7:0]  cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] out;
    int          cyc;   // -1: rely on step model only
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int unsigned euclid(input int unsigned a0, input int unsigned b0);
    int unsigned a = a0, b = b0, t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int step_model(input int unsigned x, input int unsigned y);
    int unsigned a = x, b = y;
    int n = 0;
    forever begin
      n++;
      if (a == 0 || b == 0) break;
      if (a[0] == 1'b0 && b[0] == 1'b0) begin a = a >> 1; b = b >> 1; end
      else if (a[0] == 1'b0) a = a >> 1;
      else if (b[0] == 1'b0) b = b >> 1;
      else if (a >= b) a = a - b;
      else b = b - a;
    end
    return (n > 255) ? 255 : n;
  endfunction

  // Caller is at a negedge with the DUT in IDLE or DONE.
  // poke>0 pulses START with other operands on that BUSY cycle.
  task automatic do_op(input string nm, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp_out, input int exp_cyc, input int poke);
    exp_t e;
    int   busy_n, n;
    bit   both, done;
    e.out = exp_out;
    e.cyc = 8'(step_model(x, y));
    sb.push_back(e);
    X = x; Y = y; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    X = 16'($urandom); Y = 16'($urandom);
    chk({nm, " accept ready/busy"}, {READY, BUSY}, 2'b01);
    busy_n = 1; both = 0; done = 0; n = 0;
    while (!done && n < 500) begin
      n++;
      if (n == poke) begin START = 1'b1; X = 16'd1000; Y = 16'd250; end
      @(negedge CLK);
      START = 1'b0;
      if (READY && BUSY) both = 1;
      if (READY) done = 1;
      else if (BUSY) busy_n++;
    end
    chk({nm, " completes"}, {31'd0, done}, 32'd1);
    chk({nm, " ready&busy overlap"}, {31'd0, both}, 32'd0);
    e = sb.pop_front();
    chk({nm, " OUT"}, {16'd0, OUT}, {16'd0, e.out});
    chk({nm, " CYCLES"}, {24'd0, CYCLES}, {24'd0, e.cyc});
    chk({nm, " busy cycles"}, busy_n, {24'd0, e.cyc});
    if (exp_cyc >= 0) chk({nm, " CYCLES const"}, {24'd0, CYCLES}, exp_cyc);
  endtask

  vec_t vt[9];

  initial begin
    bit          bad;
    int          n;
    logic [15:0] rx, ry;

    vt[0] = '{16'd123,   16'd456,   16'd3,     -1};
    vt[1] = '{16'd456,   16'd123,   16'd3,     -1};
    vt[2] = '{16'd456,   16'd456,   16'd456,    5};
    vt[3] = '{16'd0,     16'd37,    16'd37,     1};
    vt[4] = '{16'd0,     16'd0,     16'd0,      1};
    vt[5] = '{16'd48,    16'd18,    16'd6,      8};
    vt[6] = '{16'd65535, 16'd65535, 16'd65535, -1};
    vt[7] = '{16'd32768, 16'd16384, 16'd16384, 17};
    vt[8] = '{16'd37,    16'd0,     16'd37,     1};

    #1;
    chk("reset outputs", {OUT, READY, BUSY, CYCLES}, 26'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].out, vt[i].cyc, 0);
      if (i == 0) begin
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge CLK);
          if (OUT !== 16'd3 || READY !== 1'b1 || BUSY !== 1'b0) bad = 1;
        end
        chk("hold in DONE", {31'd0, bad}, 32'd0);
      end
    end

    // START pulsed while running must not disturb the operation
    do_op("mid-run start", 16'd123, 16'd456, 16'd3, -1, 3);

    // Asynchronous abort mid-run
    X = 16'd123; Y = 16'd456; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1 chk("async reset mid-run", {OUT, READY, BUSY, CYCLES}, 26'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("idle after reset", {READY, BUSY}, 2'b00);
    do_op("after reset", 16'd48, 16'd18, 16'd6, 8, 0);

    // Narrow build
    X8 = 8'd255; Y8 = 8'd17; START8 = 1'b1;
    @(negedge CLK);
    START8 = 1'b0;
    n = 0;
    while (!READY8 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("w8 completes", {31'd0, READY8}, 32'd1);
    chk("w8 OUT", {24'd0, OUT8}, 32'd17);
    chk("w8 CYCLES", {24'd0, CYCLES8}, step_model(255, 17));

    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i % 50 == 0) rx = 16'(rx & 16'hff00);
      do_op($sformatf("rand%0d %0d,%0d", i, rx, ry), rx, ry,
            16'(euclid(rx, ry)), -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
